uart_tx_fifo: RTL and testbench

- Byte FIFO sitting directly upstream of TX_SEND. It buffers bytes from any producer, such as a command responder or a string generator.
- It drains the buffer into TX_SEND one byte at a time over TX_SEND's wen/din/rdy handshake.
- It issues wen only after rdy has been stable high for a programmable number of cycles, then observes a guard interval before the next byte.
- This makes multi-byte messages (e.g. "VER\r\n") back-to-back safe without producer-side pacing logic.

---
 rtl/uart_tx_fifo.sv | 154 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that paces bytes into a TX_SEND transmitter.
// A byte is issued (one-cycle wen with registered din) only after rdy has
// been high for RDY_HOLD consecutive cycles. After each issue, a guard
// interval of GUARD_CYC cycles follows, during which rdy is ignored.
module uart_tx_fifo #(
    parameter int DW         = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int RDY_HOLD   = 2,
    parameter int GUARD_CYC  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic [DW-1:0]         push_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  wen,
    output logic [DW-1:0]         din,
    input  logic                  rdy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [7:0] HOLD_LAST  = 8'(RDY_HOLD - 1);
    localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_GUARD = 2'd3;

    logic [DW-1:0]         mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [1:0]            state_q, state_d;
    logic [7:0]            hold_q, hold_d;
    logic [7:0]            guard_q, guard_d;
    logic                  wen_q, wen_d;
    logic [DW-1:0]         din_q, din_d;

    logic                  push_ok;
    logic                  pop;

    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign wen      = wen_q;
    assign din      = din_q;

    // Pointer, occupancy and overflow bookkeeping; full is judged on the pre-edge count.
    always_comb begin
        push_ok    = push && !full;
        pop        = (state_q == ST_ISSUE);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push & full);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Issue sequencer: the rdy-high run is counted from the first cycle data is waiting.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        guard_d = guard_q;
        wen_d   = 1'b0;
        din_d   = din_q;
        case (state_q)
            ST_IDLE: begin
                hold_d = 8'd0;
                if (count_q != '0) begin
                    state_d = ST_ARM;
                    hold_d  = rdy ? 8'd1 : 8'd0;
                end
            end
            ST_ARM: begin
                if (!rdy) begin
                    hold_d = 8'd0;
                end else if (hold_q >= HOLD_LAST) begin
                    state_d = ST_ISSUE;
                    hold_d  = 8'd0;
                    wen_d   = 1'b1;
                    din_d   = mem[rd_ptr_q];
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_ISSUE: begin
                guard_d = 8'd0;
                state_d = ST_GUARD;
            end
            default: begin
                // Guard: rdy is deliberately ignored here, the transmitter
                // may not have lowered it yet in response to wen.
                if (guard_q >= GUARD_LAST) begin
                    guard_d = 8'd0;
                    hold_d  = 8'd0;
                    state_d = (count_q != '0) ? ST_ARM : ST_IDLE;
                end else begin
                    guard_d = guard_q + 8'd1;
                end
            end
        endcase
    end

    // Storage array write port; no reset so it maps onto RAM.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Control and output registers with asynchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            hold_q     <= 8'd0;
            guard_q    <= 8'd0;
            wen_q      <= 1'b0;
            din_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            hold_q     <= hold_d;
            guard_q    <= guard_d;
            wen_q      <= wen_d;
            din_q      <= din_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: queue-based reference model, per-cycle status
// checks, byte-order scoreboard and pacing rules, plus directed scenarios.
module tb_uart_tx_fifo;

    localparam int DEPTH     = 16;
    localparam int RDY_HOLD  = 2;
    localparam int GUARD_CYC = 2;
    localparam int SPACING   = 1 + GUARD_CYC + RDY_HOLD;

    logic       CLK = 1'b0;
    logic       RST;
    logic       push;
    logic [7:0] push_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       wen;
    logic [7:0] din;
    logic       rdy;

    uart_tx_fifo #(
        .DW(8), .DEPTH_LOG2(4), .RDY_HOLD(RDY_HOLD), .GUARD_CYC(GUARD_CYC)
    ) dut (
        .CLK(CLK), .RST(RST), .push(push), .push_data(push_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .wen(wen), .din(din), .rdy(rdy)
    );

    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] mq [$];
    logic       ovf_m = 1'b0;
    int         cyc = 0;
    int         rdy_run = 0;
    logic       wen_prev = 1'b0;
    int         n_wen = 0;
    int         last_wen_cyc = -1000;
    int         last_gap = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        ovf_m        = 1'b0;
        rdy_run      = 0;
        wen_prev     = 1'b0;
        last_wen_cyc = -1000;
    endtask

    // One clock: drive inputs, update the model at the edge, check at the negedge.
    task automatic step(input logic p, input logic [7:0] d, input logic r);
        logic full_m;
        logic wen_b;
        push      = p;
        push_data = d;
        rdy       = r;
        wen_b     = wen;
        @(posedge CLK);
        full_m = (mq.size() == DEPTH);
        if (wen_b === 1'b1 && mq.size() != 0) void'(mq.pop_front());
        if (p) begin
            if (full_m) ovf_m = 1'b1;
            else        mq.push_back(d);
        end
        rdy_run = r ? rdy_run + 1 : 0;
        cyc++;
        @(negedge CLK);
        check_eq("count", 32'(count), 32'(mq.size()));
        check_eq("empty", 32'(empty), 32'(mq.size() == 0));
        check_eq("full", 32'(full), 32'(mq.size() == DEPTH));
        check_eq("overflow", 32'(overflow), 32'(ovf_m));
        if (wen === 1'b1) begin
            check_eq("wen_width", 32'(wen_prev), 32'(0));
            check_eq("wen_nonempty", 32'(mq.size() != 0), 32'(1));
            if (mq.size() != 0) check_eq("din", 32'(din), 32'(mq[0]));
            check_eq("rdy_hold", 32'(rdy_run >= RDY_HOLD), 32'(1));
            last_gap = cyc - last_wen_cyc;
            check_eq("wen_gap", 32'(last_gap >= SPACING), 32'(1));
            last_wen_cyc = cyc;
            n_wen++;
        end
        wen_prev = wen;
    endtask

    task automatic drain();
        int k = 0;
        while (mq.size() != 0 && k < 400) begin
            step(1'b0, 8'h00, 1'b1);
            k++;
        end
        check_eq("drain_done", 32'(mq.size()), 32'(0));
        repeat (3) step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        push      = 1'b1;
        push_data = 8'hAA;
        rdy       = 1'b1;
        repeat (3) begin
            @(posedge CLK);
            @(negedge CLK);
            check_eq("rst_wen", 32'(wen), 32'(0));
            check_eq("rst_count", 32'(count), 32'(0));
            check_eq("rst_empty", 32'(empty), 32'(1));
            check_eq("rst_overflow", 32'(overflow), 32'(0));
        end
        RST  = 1'b0;
        push = 1'b0;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c_push;
        int         w0;
        int         tx_busy;
        int         idx;
        logic [3:0] gl;
        logic       r_cur;
        logic [7:0] msg [5];
        logic [7:0] got_q [$];
        logic       seen;

        RST = 1'b1; push = 1'b1; push_data = 8'h00; rdy = 1'b1;
        @(negedge CLK);
        do_reset();
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Single byte with rdy tied high: wen two cycles after the push edge.
        step(1'b1, 8'h56, 1'b1);
        c_push = cyc;
        w0 = n_wen;
        repeat (10) step(1'b0, 8'h00, 1'b1);
        check_eq("single_pulses", 32'(n_wen - w0), 32'(1));
        check_eq("single_latency", 32'(last_wen_cyc - c_push), 32'(2));
        check_eq("single_count", 32'(count), 32'(0));

        // Back-to-back bytes with rdy high: fixed spacing.
        w0 = n_wen;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b1);
        drain();
        check_eq("spacing_pulses", 32'(n_wen - w0), 32'(5));
        check_eq("spacing_gap", 32'(last_gap), 32'(SPACING));

        // "VER\r\n" into a transmitter that stays busy 10 cycles per byte.
        msg[0] = 8'h56; msg[1] = 8'h45; msg[2] = 8'h52; msg[3] = 8'h0D; msg[4] = 8'h0A;
        tx_busy = 0;
        got_q.delete();
        for (int i = 0; i < 200 && got_q.size() < 5; i++) begin
            step(i < 5, (i < 5) ? msg[i] : 8'h00, tx_busy == 0);
            if (wen === 1'b1) begin
                got_q.push_back(din);
                tx_busy = 10;
            end else if (tx_busy > 0) begin
                tx_busy--;
            end
        end
        check_eq("burst_pulses", 32'(got_q.size()), 32'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) check_eq("burst_byte", 32'(got_q[i]), 32'(msg[i]));
        end
        drain();

        // Rdy glitch: a low cycle restarts the hold count.
        step(1'b1, 8'h41, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1); gl[3] = (wen === 1'b1);
        step(1'b0, 8'h00, 1'b0); gl[2] = (wen === 1'b1);
        step(1'b0, 8'h00, 1'b1); gl[1] = (wen === 1'b1);
        step(1'b0, 8'h00, 1'b1); gl[0] = (wen === 1'b1);
        check_eq("glitch_wen", 32'(gl), 32'(4'b0001));
        drain();

        // Random traffic against the model.
        r_cur = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) r_cur = ~r_cur;
            step($urandom_range(0, 2) == 0, 8'($urandom), r_cur);
        end
        drain();

        // Overflow: 17 pushes with rdy low, the last one is lost.
        do_reset();
        repeat (2) step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        check_eq("ovf_full16", 32'(full), 32'(1));
        check_eq("ovf_not_yet", 32'(overflow), 32'(0));
        step(1'b1, 8'h10, 1'b0);
        check_eq("ovf_full", 32'(full), 32'(1));
        check_eq("ovf_count", 32'(count), 32'(16));
        check_eq("ovf_flag", 32'(overflow), 32'(1));
        w0 = n_wen;
        drain();
        check_eq("ovf_drained", 32'(n_wen - w0), 32'(16));

        // Wrap: 20 bytes pushed whenever there is room, pointers wrap.
        w0 = n_wen;
        idx = 0;
        for (int k = 0; k < 500 && idx < 20; k++) begin
            if ((k % 3 != 2) && mq.size() < DEPTH) begin
                step(1'b1, 8'(8'h80 + idx), 1'b1);
                idx++;
            end else begin
                step(1'b0, 8'h00, 1'b1);
            end
        end
        drain();
        check_eq("wrap_pulses", 32'(n_wen - w0), 32'(20));
        check_eq("wrap_overflow_sticky", 32'(overflow), 32'(1));

        // Reset asserted in the wen-high cycle.
        do_reset();
        repeat (3) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h77, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step(1'b0, 8'h00, 1'b1);
            seen = (wen === 1'b1);
        end
        check_eq("issue_seen", 32'(seen), 32'(1));
        #2;
        RST = 1'b1;
        #1;
        check_eq("async_wen", 32'(wen), 32'(0));
        check_eq("async_count", 32'(count), 32'(0));
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_clear();
        w0 = n_wen;
        repeat (20) step(1'b0, 8'h00, 1'b1);
        check_eq("post_rst_no_wen", 32'(n_wen - w0), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
